// File: rtl/dual_port_ram_clear.sv
// Simple dual-port RAM with per-lane write strobes, selectable read latency,
// same-cycle write/read bypass and a built-in constant-fill engine.
module dual_port_ram_clear #(
  parameter int MEM_SIZE_BYTES     = 14,
  parameter int MEM_WIDTH          = 16,
  parameter int WRITE_STROBE_WIDTH = 4,
  parameter int READ_LATENCY       = 1,
  parameter int BYPASS             = 1,
  localparam int MEM_SIZE          = MEM_SIZE_BYTES - $clog2(MEM_WIDTH / 8),
  localparam int WRITE_MASK_SIZE   = MEM_WIDTH / WRITE_STROBE_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MEM_WIDTH-1:0]       writeData,
  input  logic                       writeCs,
  input  logic                       write,
  input  logic [MEM_SIZE-1:0]        writeAddr,
  input  logic [WRITE_MASK_SIZE-1:0] writeMask,
  output logic [MEM_WIDTH-1:0]       readData,
  input  logic                       readCs,
  input  logic [MEM_SIZE-1:0]        readAddr,
  output logic                       readValid,
  input  logic                       clearStart,
  input  logic [MEM_WIDTH-1:0]       clearData,
  output logic                       clearBusy
);

  localparam int DEPTH = 2 ** MEM_SIZE;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } fillState_t;

  fillState_t                 r_state;
  fillState_t                 w_nextState;
  logic [MEM_SIZE-1:0]        r_counter;
  logic [MEM_SIZE-1:0]        w_nextCounter;
  logic [MEM_WIDTH-1:0]       r_clearWord;
  logic [MEM_WIDTH-1:0]       w_nextClearWord;

  logic [MEM_WIDTH-1:0]       r_mem [DEPTH];

  logic                       w_extWrite;
  logic                       w_fillWrite;
  logic                       w_wrEn;
  logic [MEM_SIZE-1:0]        w_wrAddr;
  logic [MEM_WIDTH-1:0]       w_wrData;
  logic [WRITE_MASK_SIZE-1:0] w_wrMask;
  logic [MEM_WIDTH-1:0]       w_readWord;

  logic [MEM_WIDTH-1:0]       r_rdData1;
  logic                       r_rdValid1;

  // External writes own the port; the fill only advances in cycles they leave free.
  assign w_extWrite  = writeCs & write;
  assign w_fillWrite = (r_state == S_FILL) && !w_extWrite;
  assign w_wrEn      = w_extWrite | w_fillWrite;
  assign w_wrAddr    = w_extWrite ? writeAddr : r_counter;
  assign w_wrData    = w_extWrite ? writeData : r_clearWord;
  assign w_wrMask    = w_extWrite ? writeMask : {WRITE_MASK_SIZE{1'b1}};
  assign clearBusy   = (r_state == S_FILL);

  always_comb begin
    w_nextState     = r_state;
    w_nextCounter   = r_counter;
    w_nextClearWord = r_clearWord;
    case (r_state)
      S_IDLE: begin
        if (clearStart) begin
          w_nextState     = S_FILL;
          w_nextCounter   = '0;
          w_nextClearWord = clearData;
        end
      end
      S_FILL: begin
        if (w_fillWrite) begin
          if (r_counter == {MEM_SIZE{1'b1}}) begin
            w_nextState = S_IDLE;
          end else begin
            w_nextCounter = r_counter + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_counter   <= '0;
      r_clearWord <= '0;
    end else begin
      r_state     <= w_nextState;
      r_counter   <= w_nextCounter;
      r_clearWord <= w_nextClearWord;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < WRITE_MASK_SIZE; i++) begin
        if (w_wrMask[i]) begin
          r_mem[w_wrAddr][i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH] <=
            w_wrData[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
        end
      end
    end
  end

  // Write-first merge: only lanes being written this cycle take the new data.
  always_comb begin
    w_readWord = r_mem[readAddr];
    if ((BYPASS != 0) && w_wrEn && (w_wrAddr == readAddr)) begin
      for (int i = 0; i < WRITE_MASK_SIZE; i++) begin
        if (w_wrMask[i]) begin
          w_readWord[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH] =
            w_wrData[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdData1  <= '0;
      r_rdValid1 <= 1'b0;
    end else begin
      r_rdValid1 <= readCs;
      if (readCs) begin
        r_rdData1 <= w_readWord;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : gen_lat2
      logic [MEM_WIDTH-1:0] r_rdData2;
      logic                 r_rdValid2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rdData2  <= '0;
          r_rdValid2 <= 1'b0;
        end else begin
          r_rdValid2 <= r_rdValid1;
          if (r_rdValid1) begin
            r_rdData2 <= r_rdData1;
          end
        end
      end

      assign readData  = r_rdData2;
      assign readValid = r_rdValid2;
    end else begin : gen_lat1
      assign readData  = r_rdData1;
      assign readValid = r_rdValid1;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_clear.sv
// Scoreboard bench for dual_port_ram_clear: one latency-1 write-first instance and
// one latency-2 read-first instance share every stimulus; monitors check responses.
module tb_dual_port_ram_clear;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] writeData = '0;
  logic        writeCs = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  writeAddr = '0;
  logic [3:0]  writeMask = '0;
  logic        readCs = 1'b0;
  logic [4:0]  readAddr = '0;
  logic        clearStart = 1'b0;
  logic [15:0] clearData = '0;

  logic [15:0] readDataA, readDataB;
  logic        readValidA, readValidB;
  logic        clearBusyA, clearBusyB;

  typedef struct {
    logic [15:0] data;
    int          due;
  } expect_t;

  expect_t qA[$];
  expect_t qB[$];
  int      cycleCount = 0;
  int      errorCount = 0;
  int      checkCount = 0;
  int      busyA, busyB;

  dual_port_ram_clear #(
    .MEM_SIZE_BYTES(6), .MEM_WIDTH(16), .WRITE_STROBE_WIDTH(4),
    .READ_LATENCY(1), .BYPASS(1)
  ) dutA (
    .clk(clk), .reset(reset), .writeData(writeData), .writeCs(writeCs), .write(write),
    .writeAddr(writeAddr), .writeMask(writeMask), .readData(readDataA), .readCs(readCs),
    .readAddr(readAddr), .readValid(readValidA), .clearStart(clearStart),
    .clearData(clearData), .clearBusy(clearBusyA)
  );

  dual_port_ram_clear #(
    .MEM_SIZE_BYTES(6), .MEM_WIDTH(16), .WRITE_STROBE_WIDTH(4),
    .READ_LATENCY(2), .BYPASS(0)
  ) dutB (
    .clk(clk), .reset(reset), .writeData(writeData), .writeCs(writeCs), .write(write),
    .writeAddr(writeAddr), .writeMask(writeMask), .readData(readDataB), .readCs(readCs),
    .readAddr(readAddr), .readValid(readValidB), .clearStart(clearStart),
    .clearData(clearData), .clearBusy(clearBusyB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor for the latency-1 instance: every readValid must match the oldest
  // queued expectation both in data and in the cycle it appears.
  always @(negedge clk) begin
    expect_t e;
    if (readValidA === 1'b1) begin
      if (qA.size() == 0) begin
        checkOutput("A spurious readValid", {31'd0, readValidA}, 32'd0);
      end else begin
        e = qA.pop_front();
        checkOutput("A readData", {16'd0, readDataA}, {16'd0, e.data});
        checkOutput("A read latency", cycleCount, e.due);
      end
    end else if (qA.size() > 0 && qA[0].due <= cycleCount) begin
      e = qA.pop_front();
      checkOutput("A missing readValid", {31'd0, readValidA}, 32'd1);
    end
  end

  // Same monitor for the latency-2 instance.
  always @(negedge clk) begin
    expect_t e;
    if (readValidB === 1'b1) begin
      if (qB.size() == 0) begin
        checkOutput("B spurious readValid", {31'd0, readValidB}, 32'd0);
      end else begin
        e = qB.pop_front();
        checkOutput("B readData", {16'd0, readDataB}, {16'd0, e.data});
        checkOutput("B read latency", cycleCount, e.due);
      end
    end else if (qB.size() > 0 && qB[0].due <= cycleCount) begin
      e = qB.pop_front();
      checkOutput("B missing readValid", {31'd0, readValidB}, 32'd1);
    end
  end

  // One clock of stimulus; called and returns at posedge+1.
  task automatic applyStimulus(input logic cs, input logic we, input logic [4:0] wa,
                               input logic [15:0] wd, input logic [3:0] wm,
                               input logic rd, input logic [4:0] ra,
                               input logic [15:0] expA, input logic [15:0] expB);
    writeCs   = cs;
    write     = we;
    writeAddr = wa;
    writeData = wd;
    writeMask = wm;
    readCs    = rd;
    readAddr  = ra;
    if (rd) begin
      qA.push_back(expect_t'{expA, cycleCount + 1});
      qB.push_back(expect_t'{expB, cycleCount + 2});
    end
    @(posedge clk);
    #1;
    writeCs    = 1'b0;
    write      = 1'b0;
    readCs     = 1'b0;
    clearStart = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readBoth(input logic [4:0] ra, input logic [15:0] exp);
    applyStimulus(0, 0, 0, 0, 0, 1, ra, exp, exp);
  endtask

  // Starts a fill and steps through it, counting busy cycles per instance.
  task automatic runFill(input logic [15:0] word,
                         input int c0, input logic [4:0] a0,
                         input int c1, input logic [4:0] a1, input logic [15:0] cd,
                         input int lateStartAt, input int resetAt,
                         input int rdCycle, input logic [4:0] rdA, input logic [15:0] rdExp,
                         output int bA, output int bB);
    logic hit;
    clearStart = 1'b1;
    clearData  = word;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clearData = ~word;
    bA = 0;
    bB = 0;
    for (int n = 0; n < 100; n++) begin
      if (!clearBusyA && !clearBusyB) break;
      if (clearBusyA) bA++;
      if (clearBusyB) bB++;
      if (n == resetAt) begin
        reset = 1'b1;
        break;
      end
      if (n == lateStartAt) begin
        clearStart = 1'b1;
        clearData  = 16'h1111;
      end
      hit = (n == c0) || (n == c1);
      applyStimulus(hit, hit, (n == c0) ? a0 : a1, cd, 4'hF,
                    (n == rdCycle), rdA, rdExp, rdExp);
    end
  endtask

  initial begin
    $display("[TB] starting dual_port_ram_clear bench");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset readData A", {16'd0, readDataA}, 32'd0);
    checkOutput("reset readData B", {16'd0, readDataB}, 32'd0);
    checkOutput("reset readValid A", {31'd0, readValidA}, 32'd0);
    checkOutput("reset readValid B", {31'd0, readValidB}, 32'd0);
    checkOutput("reset clearBusy A", {31'd0, clearBusyA}, 32'd0);
    checkOutput("reset clearBusy B", {31'd0, clearBusyB}, 32'd0);
    reset = 1'b0;
    idleCycles(2);

    // Basic write/read, plus writeCs/write gating
    applyStimulus(1, 1, 5'd5, 16'hABCD, 4'hF, 0, 0, 0, 0);
    readBoth(5'd5, 16'hABCD);
    applyStimulus(1, 0, 5'd5, 16'h0000, 4'hF, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd5, 16'h0000, 4'hF, 0, 0, 0, 0);
    readBoth(5'd5, 16'hABCD);
    idleCycles(3);

    // Partial mask
    applyStimulus(1, 1, 5'd3, 16'h1234, 4'hF, 0, 0, 0, 0);
    applyStimulus(1, 1, 5'd3, 16'hFFFF, 4'h5, 0, 0, 0, 0);
    readBoth(5'd3, 16'h1F3F);
    idleCycles(3);

    // Same-cycle collision, then a write one cycle after the read
    applyStimulus(1, 1, 5'd7, 16'h0000, 4'hF, 0, 0, 0, 0);
    applyStimulus(1, 1, 5'd7, 16'h5678, 4'h3, 1, 5'd7, 16'h0078, 16'h0000);
    readBoth(5'd7, 16'h0078);
    applyStimulus(1, 1, 5'd7, 16'hFFFF, 4'hF, 0, 0, 0, 0);
    readBoth(5'd7, 16'hFFFF);
    idleCycles(4);
    checkOutput("hold readData A", {16'd0, readDataA}, 32'h0000FFFF);
    checkOutput("hold readData B", {16'd0, readDataB}, 32'h0000FFFF);
    checkOutput("idle readValid A", {31'd0, readValidA}, 32'd0);

    // Warm-up fill, then a fill accepted in the first idle cycle; mid-fill start ignored
    runFill(16'h1234, -1, 0, -1, 0, 0, -1, -1, -1, 0, 0, busyA, busyB);
    checkOutput("warm fill busy A", busyA, 32'd32);
    checkOutput("warm fill busy B", busyB, 32'd32);
    runFill(16'hBEEF, -1, 0, -1, 0, 0, 5, -1, -1, 0, 0, busyA, busyB);
    checkOutput("fill busy A", busyA, 32'd32);
    checkOutput("fill busy B", busyB, 32'd32);
    for (int a = 0; a < 32; a++) readBoth(a[4:0], 16'hBEEF);
    idleCycles(3);

    // Fill with two external-write conflicts
    runFill(16'h0000, 2, 5'd30, 10, 5'd0, 16'h9999, -1, -1, -1, 0, 0, busyA, busyB);
    checkOutput("conflict fill busy A", busyA, 32'd34);
    checkOutput("conflict fill busy B", busyB, 32'd34);
    readBoth(5'd30, 16'h0000);
    readBoth(5'd0, 16'h9999);
    readBoth(5'd29, 16'h0000);
    readBoth(5'd1, 16'h0000);
    idleCycles(3);

    // Reset during fill cycle 10, with a completed read just before it
    runFill(16'hA5A5, -1, 0, -1, 0, 0, -1, 10, 7, 5'd5, 16'hA5A5, busyA, busyB);
    #1;
    checkOutput("abort clearBusy A", {31'd0, clearBusyA}, 32'd0);
    checkOutput("abort clearBusy B", {31'd0, clearBusyB}, 32'd0);
    checkOutput("abort readData A", {16'd0, readDataA}, 32'd0);
    checkOutput("abort readData B", {16'd0, readDataB}, 32'd0);
    checkOutput("abort readValid A", {31'd0, readValidA}, 32'd0);
    checkOutput("abort readValid B", {31'd0, readValidB}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles(1);
    for (int a = 0; a < 32; a++) readBoth(a[4:0], (a < 10) ? 16'hA5A5 : 16'h0000);
    idleCycles(4);
    checkOutput("queue A drained", qA.size(), 32'd0);
    checkOutput("queue B drained", qB.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_clear.md
Name: dual_port_ram_clear

Overview:
Successor to the team's simple dual-port RAM: one write port, one read port, per-lane write strobes, now generalised with a selectable read latency and a `readValid` strobe. It adds same-cycle write-to-read bypass and a built-in fill engine that writes a constant word to every address. It is intended for framebuffer and depth-buffer tiles, where fast clears and collision-safe reads are required.

Parameters:
MEM_SIZE_BYTES, 14, memory size as a power of two in bytes.
MEM_WIDTH, 16, word width in bits; must be a multiple of WRITE_STROBE_WIDTH and of 8.
WRITE_STROBE_WIDTH, 4, bits controlled by one mask bit.
READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
BYPASS, 1, 1 = write-first per lane on address collision, 0 = read-first.
MEM_SIZE (derived), MEM_SIZE_BYTES - clog2(MEM_WIDTH/8), address width.
WRITE_MASK_SIZE (derived), MEM_WIDTH/WRITE_STROBE_WIDTH, number of lanes.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
writeData  in  MEM_WIDTH  write word
writeCs  in  1  write port select
write  in  1  write enable; a write occurs only when writeCs & write
writeAddr  in  MEM_SIZE  write address
writeMask  in  WRITE_MASK_SIZE  per-lane write enable
readData  out  MEM_WIDTH  read word
readCs  in  1  read request
readAddr  in  MEM_SIZE  read address
readValid  out  1  high in the cycle readData carries a requested word
clearStart  in  1  single-cycle pulse that starts a fill
clearData  in  MEM_WIDTH  fill word, sampled on accepted clearStart
clearBusy  out  1  fill in progress

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset values: readData=0, readValid=0, clearBusy=0, fill counter=0, latched fill word=0, pipeline stages=0. Memory contents are not reset.
- Reset asserted mid-fill aborts the fill immediately; words already written keep their fill value.
- External write: when writeCs & write, lane i of mem[writeAddr] takes writeData lane i if writeMask[i]. Lanes with a clear mask bit are untouched.
- Read: when readCs is high at cycle t, readData shows mem[readAddr] at cycle t+READ_LATENCY and readValid is high in that same cycle.
- readData holds its last value when no new read completes. readValid is high exactly one cycle per request. Back-to-back reads give full throughput.
- Collision (read and write to the same address in the same cycle):
  - BYPASS=1: masked lanes return the new data, unmasked lanes return the old data.
  - BYPASS=0: all lanes return the old data.
  - Only same-cycle collisions are handled. A write at t+1 does not alter a read issued at t.
- Fill engine, state machine IDLE -> FILL -> IDLE:
  - IDLE: clearStart=1 latches clearData, sets counter=0, and enters FILL. clearBusy goes high at the next edge.
  - FILL: each cycle with no external write (writeCs & write low), write the latched word with all lanes enabled to mem[counter], then increment counter.
  - FILL, counter == 2^MEM_SIZE-1 and the write is issued: return to IDLE, so clearBusy is low the following cycle.
  - FILL, external write present: the external write takes the write port and the counter stalls for that cycle.
  - An external write to an address not yet reached is later overwritten by the fill. An external write to an address already filled persists.
  - clearStart while clearBusy=1 is ignored and the latched word is unchanged.
  - clearStart in the first cycle after clearBusy falls is accepted.
  - With no conflicts, clearBusy is high for exactly 2^MEM_SIZE cycles.
- Reads are allowed during a fill. Fill writes count as full-mask writes for collision and bypass purposes.
- Width rules: counter is MEM_SIZE bits and compares against all-ones; there is no wrap past the last address.

Test Plan:
(Use MEM_SIZE_BYTES=6, MEM_WIDTH=16, WRITE_STROBE_WIDTH=4: 32 words, 4 lanes.)
1. Basic read, READ_LATENCY=1: write 0xABCD to addr 5 with mask 0xF, read addr 5 next cycle -> readData=0xABCD with readValid one cycle after readCs. Repeat with READ_LATENCY=2 -> response two cycles after readCs.
2. Partial mask: mem[3]=0x1234, write 0xFFFF with mask 0x5 -> read returns 0x1F3F.
3. Collision: mem[7]=0x0000; same cycle write 0x5678 mask 0x3 and read addr 7 -> BYPASS=1 gives 0x0078; BYPASS=0 gives 0x0000.
4. Full fill: clearStart with clearData=0xBEEF, no other traffic -> clearBusy high exactly 32 cycles, then all 32 addresses read 0xBEEF; a second clearStart (0x1111) mid-fill is ignored.
5. Fill with conflicts: fill 0x0000 started; externally write 0x9999 to addr 30 at fill cycle 2 and to addr 0 at fill cycle 10 -> busy lasts 34 cycles, addr 30 reads 0x0000, addr 0 reads 0x9999.
6. Reset mid-fill: assert reset at fill cycle 10 -> clearBusy, readData and readValid are 0 immediately; addrs 0-9 hold the fill word and addrs 10+ are unchanged.
